// File: rtl/insn_load_ctrl_pkg.sv
// Shared core defines for the instruction-memory loader: sizes, derived widths
// and loader state encoding.
package insn_load_ctrl_pkg;

  localparam int unsigned INSN_SIZE      = 16;
  localparam int unsigned INSN_BUS_COUNT = 4;
  localparam int unsigned INSN_LOAD_TIME = 4;
  localparam int unsigned INSN_COUNT     = INSN_BUS_COUNT * INSN_LOAD_TIME;

  // Derived widths (the former *_RANGE defines)
  localparam int unsigned INSN_BUS_W     = INSN_SIZE * INSN_BUS_COUNT;
  localparam int unsigned LOAD_CNT_W     = (INSN_LOAD_TIME > 1) ? $clog2(INSN_LOAD_TIME) : 1;
  localparam int unsigned INSN_PTR_W     = (INSN_COUNT > 1) ? $clog2(INSN_COUNT) : 1;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_LOAD = 2'd1,
    LD_DONE = 2'd2
  } ld_state_t;

endpackage

// File: rtl/insn_load_ctrl.sv
// Instruction-memory loader: accepts program beats over valid/ready and drives
// the memory load interface one registered write per accepted beat.
module insn_load_ctrl
  import insn_load_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic                  load_abort,
  input  logic                  bus_valid,
  input  logic [INSN_BUS_W-1:0] bus_data,
  output logic                  bus_ready,
  output logic                  init_insn_mem,
  output logic [INSN_BUS_W-1:0] insn_data,
  output logic [LOAD_CNT_W-1:0] insn_load_counter,
  output logic                  load_busy,
  output logic                  load_done,
  output logic                  load_aborted
);

  ld_state_t             state;
  ld_state_t             state_nxt;
  logic [LOAD_CNT_W-1:0] beat_cnt;
  logic                  accept;
  logic                  last_beat;

  assign last_beat = (beat_cnt == LOAD_CNT_W'(INSN_LOAD_TIME - 1));

  always_comb begin
    state_nxt = state;
    // abort gates ready so a beat offered in the abort cycle is never taken
    bus_ready = (state == LD_LOAD) && !load_abort;
    accept    = bus_valid && bus_ready;
    case (state)
      LD_IDLE: if (load_start) state_nxt = LD_LOAD;
      LD_LOAD: begin
        if (load_abort)              state_nxt = LD_IDLE;
        else if (accept && last_beat) state_nxt = LD_DONE;
      end
      LD_DONE: state_nxt = LD_IDLE;
      default: state_nxt = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= LD_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_cnt          <= '0;
      init_insn_mem     <= 1'b0;
      insn_data         <= '0;
      insn_load_counter <= '0;
      load_busy         <= 1'b0;
      load_done         <= 1'b0;
      load_aborted      <= 1'b0;
    end else begin
      init_insn_mem <= accept;
      if (accept) begin
        insn_data         <= bus_data;
        insn_load_counter <= beat_cnt;
      end
      // counter saturates on the last beat; only a new start clears it
      if (state == LD_IDLE && load_start) beat_cnt <= '0;
      else if (accept && !last_beat)      beat_cnt <= beat_cnt + 1'b1;
      load_busy    <= (state_nxt != LD_IDLE);
      load_done    <= (state_nxt == LD_DONE);
      load_aborted <= (state == LD_LOAD) && load_abort;
    end
  end

endmodule
